// File: rtl/tic_tac_toe_ai.sv
// tic_tac_toe_ai: picks the computer's next move (win, else block, else preferred cell) and strobes it out
module tic_tac_toe_ai #(
  parameter int PC_HOLD = 5,
  parameter logic [1:0] CPU_MARK = 2'b10,
  parameter logic [1:0] PLY_MARK = 2'b01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] who,
  output logic [3:0] computer_position,
  output logic       pc,
  output logic       busy,
  output logic       no_move
);
  typedef enum logic [2:0] {IDLE, WIN_SCAN, BLK_SCAN, PREF, ISSUE} state_t;
  localparam logic [7:0][2:0][3:0] LINES = {12'h246, 12'h048, 12'h258, 12'h147,
                                            12'h036, 12'h678, 12'h345, 12'h012};
  localparam logic [8:0][3:0] ORD = {4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4};
  state_t r_state, w_state_n;
  logic [2:0] r_idx, w_idx_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic [3:0] r_pos, w_pos_n;
  logic r_pc, w_pc_n;
  logic r_pend, w_pend_n;
  logic r_no_move;
  logic [8:0][1:0] r_b;
  logic [8:0][1:0] w_in;
  logic [8:0] w_occ;
  logic [2:0][3:0] w_l;
  logic [1:0] w_a, w_b, w_c, w_m;
  logic w_h0, w_h1, w_h2, w_hit, w_refuse, w_start;
  logic [3:0] w_hcell, w_pref;
  assign w_in = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  for (genvar g = 0; g < 9; g++) begin : g_occ
    assign w_occ[g] = |w_in[g];
  end
  assign w_refuse = (who != 2'b00) || (&w_occ);
  assign w_start = (r_state == IDLE) && go && !w_refuse;
  assign w_l = LINES[r_idx];
  assign w_a = r_b[w_l[0]];
  assign w_b = r_b[w_l[1]];
  assign w_c = r_b[w_l[2]];
  assign w_m = (r_state == WIN_SCAN) ? CPU_MARK : PLY_MARK;
  assign w_h0 = (w_a == 2'b00) && (w_b == w_m) && (w_c == w_m);
  assign w_h1 = (w_b == 2'b00) && (w_a == w_m) && (w_c == w_m);
  assign w_h2 = (w_c == 2'b00) && (w_a == w_m) && (w_b == w_m);
  assign w_hit = w_h0 || w_h1 || w_h2;
  assign w_hcell = w_h0 ? w_l[0] : w_h1 ? w_l[1] : w_l[2];
  assign busy = r_state != IDLE;
  assign pc = r_pc;
  assign computer_position = r_pos;
  assign no_move = r_no_move;
  // first empty cell in centre/corner/edge preference order
  always_comb begin
    w_pref = 4'd0;
    for (int k = 8; k >= 0; k--)
      if (r_b[ORD[k]] == 2'b00) w_pref = ORD[k];
  end
  // next-state: scan one line per cycle, win lines before block lines, then fall back to preference
  always_comb begin
    w_state_n = r_state;
    w_idx_n = r_idx;
    w_cnt_n = r_cnt;
    w_pc_n = r_pc;
    w_pos_n = r_pos;
    w_pend_n = 1'b0;
    case (r_state)
      IDLE: begin
        w_pend_n = go && w_refuse;
        w_state_n = w_start ? WIN_SCAN : IDLE;
        w_idx_n = 3'd0;
      end
      WIN_SCAN, BLK_SCAN: begin
        if (w_hit) begin
          w_pos_n = w_hcell;
          w_pc_n = 1'b1;
          w_cnt_n = 4'(PC_HOLD - 1);
          w_state_n = ISSUE;
        end else if (r_idx == 3'd7) begin
          w_idx_n = 3'd0;
          w_state_n = (r_state == WIN_SCAN) ? BLK_SCAN : PREF;
        end else w_idx_n = r_idx + 3'd1;
      end
      PREF: begin
        w_pos_n = w_pref;
        w_pc_n = 1'b1;
        w_cnt_n = 4'(PC_HOLD - 1);
        w_state_n = ISSUE;
      end
      ISSUE: begin
        w_pc_n = r_cnt != 4'd0;
        w_cnt_n = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
        w_state_n = (r_cnt != 4'd0) ? ISSUE : IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end
  // state register; the board is frozen on the accepted go so later input changes are ignored
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx <= 3'd0;
      r_cnt <= 4'd0;
      r_pc <= 1'b0;
      r_pos <= 4'd0;
      r_pend <= 1'b0;
      r_no_move <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      r_cnt <= w_cnt_n;
      r_pc <= w_pc_n;
      r_pos <= w_pos_n;
      r_pend <= w_pend_n;
      r_no_move <= r_pend;
      if (w_start) r_b <= w_in;
    end
  end
endmodule

// File: tb/tb_tic_tac_toe_ai.sv
// tb_tic_tac_toe_ai: directed moves checked through an expected-event scoreboard
module tb_tic_tac_toe_ai;
  localparam logic [1:0] E = 2'b00, C = 2'b10, P = 2'b01, X = 2'b11;
  typedef struct {bit nm; logic [3:0] pos; int cyc;} exp_t;
  logic clock = 0, reset = 0, go = 0;
  logic [17:0] bd = '0;
  logic [1:0] who = 2'b00;
  logic [3:0] computer_position;
  logic pc, busy, no_move;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  tic_tac_toe_ai dut (
    .clock(clock), .reset(reset), .go(go),
    .pos1(bd[1:0]), .pos2(bd[3:2]), .pos3(bd[5:4]), .pos4(bd[7:6]), .pos5(bd[9:8]),
    .pos6(bd[11:10]), .pos7(bd[13:12]), .pos8(bd[15:14]), .pos9(bd[17:16]),
    .who(who), .computer_position(computer_position), .pc(pc), .busy(busy), .no_move(no_move)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  function automatic logic [17:0] brd(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction
  // monitor: pops an expectation on every pc rise or no_move pulse and checks the strobe width
  bit pc_prev = 0, stable_bad = 0;
  int hold_n = 0;
  logic [3:0] hold_pos = '0;
  always @(negedge clock) begin
    exp_t e;
    if (pc && !pc_prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pc pos=%0d cyc=%0d required none", computer_position, cyc);
      end else begin
        e = q.pop_front();
        if (e.nm || computer_position != e.pos || cyc != e.cyc) begin
          errors++;
          $display("FAIL move got pc pos=%0d cyc=%0d required nm=%0d pos=%0d cyc=%0d",
                   computer_position, cyc, e.nm, e.pos, e.cyc);
        end
      end
      hold_n = 1;
      hold_pos = computer_position;
      stable_bad = 0;
    end else if (pc) begin
      hold_n++;
      if (computer_position != hold_pos) stable_bad = 1;
    end
    if (!pc && pc_prev && reset) begin
      checks++;
      if (hold_n != 5 || stable_bad || busy) begin
        errors++;
        $display("FAIL pc_hold got len=%0d unstable=%0d busy=%0d required len=5 unstable=0 busy=0",
                 hold_n, stable_bad, busy);
      end
    end
    if (no_move) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_no_move cyc=%0d required none", cyc);
      end else begin
        e = q.pop_front();
        if (!e.nm || cyc != e.cyc || pc || busy) begin
          errors++;
          $display("FAIL no_move got cyc=%0d pc=%0d busy=%0d required nm=%0d cyc=%0d pc=0 busy=0",
                   cyc, pc, busy, e.nm, e.cyc);
        end
      end
    end
    pc_prev = pc;
  end
  task automatic run(input string name, input logic [17:0] b, input logic [1:0] w, input bit nm,
                     input logic [3:0] p, input int lat, input bit busy_go);
    int t;
    bit done = 0, saw_busy = 0;
    exp_t e;
    @(negedge clock);
    bd = b;
    who = w;
    go = 1;
    @(posedge clock);
    #1;
    t = cyc;
    e.nm = nm;
    e.pos = p;
    e.cyc = t + lat;
    q.push_back(e);
    go = 0;
    bd = {9{X}};
    who = 2'b01;
    @(negedge clock);
    checks++;
    if (busy != !nm) begin
      errors++;
      $display("FAIL %s busy_after_go got %0d required %0d", name, busy, !nm);
    end
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy_go && i == 3) go = 1;
      if (busy_go && i == 4) go = 0;
      @(negedge clock);
      if (busy) saw_busy = 1;
      if (i >= 3 && !busy && !pc) done = 1;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (!done || q.size() != 0) begin
      errors++;
      $display("FAIL %s completion got done=%0d pending=%0d required done=1 pending=0", name, done, q.size());
      q.delete();
    end
    if (nm) begin
      checks++;
      if (saw_busy) begin
        errors++;
        $display("FAIL %s refused_busy got 1 required 0", name);
      end
    end
  endtask
  initial begin
    int t;
    repeat (3) @(negedge clock);
    checks++;
    if (pc || busy || no_move || computer_position != 4'd0) begin
      errors++;
      $display("FAIL reset_state got pc=%0d busy=%0d nm=%0d pos=%0d required 0 0 0 0",
               pc, busy, no_move, computer_position);
    end
    reset = 1;
    run("empty", brd(E, E, E, E, E, E, E, E, E), 2'b00, 0, 4'd4, 17, 0);
    run("win_l0", brd(C, C, E, E, E, E, E, E, E), 2'b00, 0, 4'd2, 1, 0);
    run("block_l6", brd(P, E, C, E, P, E, E, E, E), 2'b00, 0, 4'd8, 15, 0);
    run("win_over_block", brd(E, E, E, C, C, E, P, P, E), 2'b00, 0, 4'd5, 2, 0);
    run("win_l7", brd(E, E, C, E, C, E, E, E, E), 2'b00, 0, 4'd6, 8, 0);
    run("block_l0", brd(P, E, P, E, C, E, E, E, E), 2'b00, 0, 4'd1, 9, 0);
    run("pref_corner", brd(E, E, E, E, P, E, E, E, E), 2'b00, 0, 4'd0, 17, 0);
    run("illegal_cell", brd(X, C, E, E, E, E, E, E, E), 2'b00, 0, 4'd4, 17, 0);
    run("pref_after_x", brd(X, E, E, E, C, E, E, E, E), 2'b00, 0, 4'd2, 17, 0);
    run("game_over", brd(E, E, E, E, E, E, E, E, E), 2'b01, 1, 4'd0, 1, 0);
    run("board_full", brd(C, P, C, P, C, P, P, C, P), 2'b00, 1, 4'd0, 1, 0);
    run("go_while_busy", brd(E, E, E, E, E, E, E, E, E), 2'b00, 0, 4'd4, 17, 1);
    @(negedge clock);
    bd = brd(E, E, E, E, E, E, E, E, E);
    who = 2'b00;
    go = 1;
    @(posedge clock);
    #1;
    t = cyc;
    go = 0;
    repeat (4) @(negedge clock);
    go = 1;
    @(negedge clock);
    go = 0;
    repeat (6) @(negedge clock);
    reset = 0;
    @(negedge clock);
    checks++;
    if (pc || busy || no_move || computer_position != 4'd0) begin
      errors++;
      $display("FAIL reset_mid_scan got pc=%0d busy=%0d nm=%0d pos=%0d required 0 0 0 0 (t=%0d)",
               pc, busy, no_move, computer_position, t);
    end
    reset = 1;
    repeat (30) @(negedge clock);
    checks++;
    if (busy || pc) begin
      errors++;
      $display("FAIL after_reset_idle got busy=%0d pc=%0d required 0 0", busy, pc);
    end
    run("restart", brd(E, E, E, E, E, E, E, E, E), 2'b00, 0, 4'd4, 17, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tic_tac_toe_ai.md
TIC_TAC_TOE_AI -- requirements
Module: tic_tac_toe_ai

Interface
REQ-001 The block SHALL have three parameters, one per line: name, default, meaning.
- PC_HOLD, 5, number of cycles pc is held high per issued move (range 1..15).
- CPU_MARK, 2'b10, pos code for a computer-owned cell.
- PLY_MARK, 2'b01, pos code for a player-owned cell.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous, active-low reset.
- go, in, 1, request one computer move; sampled only in IDLE.
- pos1..pos9, in, 2 each, board cells; 00 empty, CPU_MARK computer, PLY_MARK player, 11 occupied/illegal.
- who, in, 2, game result; 00 game in progress, any other value game over.
- computer_position, out, 4, chosen cell index 0..8 (0 = pos1 ... 8 = pos9).
- pc, out, 1, move strobe to the game block, held PC_HOLD cycles.
- busy, out, 1, high in every state except IDLE.
- no_move, out, 1, one-cycle pulse: request refused (game over or board full).

Function
REQ-003 The FSM SHALL have the states IDLE, WIN_SCAN, BLK_SCAN, PREF and ISSUE, with a 3-bit line index and a 4-bit hold counter.
REQ-004 On the edge t where go=1 in IDLE, the block SHALL snapshot pos1..pos9 and who; later input changes SHALL NOT affect the move being computed.
REQ-005 If the snapshot has who!=00 or no 00 cell, the block SHALL pulse no_move high for one cycle after edge t+1, stay in IDLE and leave pc low.
REQ-006 Otherwise the block SHALL enter WIN_SCAN with idx=0.
REQ-007 The lines SHALL be L0(0,1,2) L1(3,4,5) L2(6,7,8) L3(0,3,6) L4(1,4,7) L5(2,5,8) L6(0,4,8) L7(2,4,6), with one line evaluated per cycle in ascending order.
REQ-008 A line SHALL hit for mark M when exactly one cell is 00 and the other two equal M; the hit cell is that empty cell.
REQ-009 In WIN_SCAN, on edge t+1+i the block SHALL evaluate line i for CPU_MARK.
- Hit: register computer_position, set pc=1 and go to ISSUE.
- No hit at i=7: go to BLK_SCAN with idx=0.
REQ-010 BLK_SCAN SHALL behave identically with PLY_MARK, evaluating line j on edge t+9+j; no hit at j=7 SHALL go to PREF.
REQ-011 On edge t+17, PREF SHALL select the first empty cell in the order 4,0,2,6,8,1,3,5,7, set pc=1 and go to ISSUE.
REQ-012 In ISSUE, pc and computer_position SHALL remain stable for exactly PC_HOLD cycles, after which pc=0 and the state returns to IDLE.
REQ-013 computer_position SHALL hold its last value until the next move is issued.
REQ-014 A win hit SHALL take priority over a block hit, and a lower line index SHALL take priority over a higher one.
REQ-015 go asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 A cell coded 11 SHALL be treated as occupied and SHALL never match CPU_MARK or PLY_MARK.
REQ-017 The worst-case latency from the go edge to pc rising SHALL be 17 cycles.
REQ-018 The block SHALL issue at most one move per go.

Reset
REQ-019 While reset=0 at a rising edge, the block SHALL set state=IDLE, idx=0, hold counter=0, pc=0, busy=0, no_move=0 and computer_position=0.
REQ-020 Reset asserted mid-scan or mid-ISSUE SHALL abort the move, drop pc on the next edge and produce no no_move pulse.
REQ-021 After reset is released, the first edge with go=1 SHALL start a new request.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Empty board, go -> pc high after edge t+17, computer_position=4, pc high 5 cycles, then busy=0.
- pos1=pos2=CPU, rest empty, go -> L0 win hit, pc after edge t+1, computer_position=2.
- pos1=pos5=PLY, pos3=CPU, rest empty, go -> no win; L6 block hit, pc after edge t+15, computer_position=8.
- pos4=pos5=CPU and pos7=pos8=PLY, go -> win over block, L1 hit, pc after edge t+2, computer_position=5.
- who=01 or full board, go -> single no_move pulse after edge t+1, pc stays 0, busy stays 0.
- Reset=0 during BLK_SCAN, and go pulsed while busy -> all outputs return to reset values, no pc; the extra go produces nothing.
